// File: rtl/pwm_pkg.sv
// Shared definitions for the multi-channel PWM controller and its bench:
// alignment modes and the default timing parameters.
package pwm_pkg;

  typedef enum logic {
    MODE_EDGE   = 1'b0,
    MODE_CENTER = 1'b1
  } pwm_mode_e;

  localparam int DEF_NUM_CH    = 4;
  localparam int DEF_PERIOD    = 100;
  localparam int DEF_DUTY_STEP = 10;
  localparam int DEF_DEB_DIV   = 250000;

endpackage

// File: rtl/btn_debounce.sv
// Push-button conditioner: two-flop synchroniser, then a slow two-stage sampler
// advanced on the shared prescaler tick; emits a single-cycle rising-edge press.
module btn_debounce (
  input  logic clk,
  input  logic rst,
  input  logic tick,
  input  logic btn_raw,
  output logic press
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;
  logic s1_q, s1_d;
  logic s2_q, s2_d;

  always_comb begin
    meta_d = btn_raw;
    sync_d = meta_q;
    s1_d   = s1_q;
    s2_d   = s2_q;
    if (tick) begin
      s1_d = sync_q;
      s2_d = s1_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      s1_q   <= 1'b0;
      s2_q   <= 1'b0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
      s1_q   <= s1_d;
      s2_q   <= s2_d;
    end
  end

  // Qualified by tick so a held button yields exactly one pulse.
  assign press = s1_q & ~s2_q & tick;

endmodule

// File: rtl/pwm_multi_ctrl.sv
// Multi-channel PWM generator: one shared period counter, per-channel shadow/active
// duty registers stepped by debounced buttons, edge- or centre-aligned compare.
module pwm_multi_ctrl
  import pwm_pkg::*;
#(
  parameter int NUM_CH    = DEF_NUM_CH,
  parameter int PERIOD    = DEF_PERIOD,
  parameter int DUTY_STEP = DEF_DUTY_STEP,
  parameter int DEB_DIV   = DEF_DEB_DIV,
  localparam int CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  localparam int CNT_W    = $clog2(PERIOD + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ena,
  input  logic              btn_inc,
  input  logic              btn_dec,
  input  logic [CH_W-1:0]   ch_sel,
  input  logic              center_mode,
  output logic [NUM_CH-1:0] pwm_out,
  output logic [CNT_W-1:0]  duty_sel,
  output logic              period_strt
);

  localparam int DIV_W = (DEB_DIV > 1) ? $clog2(DEB_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DEB_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PERIOD - 1);
  localparam logic [CNT_W-1:0] DUTY_RST = CNT_W'(PERIOD / 2);
  localparam logic [CNT_W-1:0] DUTY_MAX = CNT_W'(PERIOD);
  localparam logic [CNT_W:0]   PERIOD_X = (CNT_W + 1)'(PERIOD);
  localparam logic [CNT_W:0]   STEP_X   = (CNT_W + 1)'(DUTY_STEP);

  logic [DIV_W-1:0] presc_q, presc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  pwm_mode_e        mode_q, mode_d;
  logic             strt_q, strt_d;
  logic             tick;
  logic             boundary;
  logic             inc_press;
  logic             dec_press;
  logic [NUM_CH*CNT_W-1:0] shadow_flat;

  assign tick     = ena & (presc_q == DIV_LAST);
  assign boundary = ena & (cnt_q == CNT_LAST);

  always_comb begin
    presc_d = presc_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    strt_d  = 1'b0;
    if (ena) begin
      presc_d = (presc_q == DIV_LAST) ? '0 : presc_q + DIV_W'(1);
      cnt_d   = boundary ? '0 : cnt_q + CNT_W'(1);
      strt_d  = (cnt_q == '0);
      if (boundary) begin
        mode_d = center_mode ? MODE_CENTER : MODE_EDGE;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc_q <= '0;
      cnt_q   <= '0;
      mode_q  <= MODE_EDGE;
      strt_q  <= 1'b0;
    end else begin
      presc_q <= presc_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
      strt_q  <= strt_d;
    end
  end

  assign period_strt = strt_q;

  btn_debounce u_deb_inc (
    .clk     (clk),
    .rst     (rst),
    .tick    (tick),
    .btn_raw (btn_inc),
    .press   (inc_press)
  );

  btn_debounce u_deb_dec (
    .clk     (clk),
    .rst     (rst),
    .tick    (tick),
    .btn_raw (btn_dec),
    .press   (dec_press)
  );

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    logic [CNT_W-1:0] shadow_q, shadow_d;
    logic [CNT_W-1:0] active_q, active_d;
    logic             pwm_q, pwm_d;
    logic             sel_hit;
    logic [CNT_W:0]   inc_sum;
    logic [CNT_W:0]   lo;
    logic [CNT_W:0]   hi;

    assign sel_hit = (ch_sel == CH_W'(gi));

    always_comb begin
      inc_sum  = {1'b0, shadow_q} + STEP_X;
      shadow_d = shadow_q;
      if (sel_hit && inc_press && !dec_press) begin
        shadow_d = (inc_sum > PERIOD_X) ? DUTY_MAX : inc_sum[CNT_W-1:0];
      end else if (sel_hit && dec_press && !inc_press) begin
        shadow_d = ({1'b0, shadow_q} < STEP_X) ? '0 : shadow_q - CNT_W'(DUTY_STEP);
      end
      // Active takes the pre-press shadow; a press on the boundary cycle waits a period.
      active_d = boundary ? shadow_q : active_q;
      lo       = (PERIOD_X - {1'b0, active_q}) >> 1;
      hi       = lo + {1'b0, active_q};
      pwm_d    = 1'b0;
      if (ena) begin
        if (mode_q == MODE_CENTER) begin
          pwm_d = ({1'b0, cnt_q} >= lo) && ({1'b0, cnt_q} < hi);
        end else begin
          pwm_d = (cnt_q < active_q);
        end
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        shadow_q <= DUTY_RST;
        active_q <= DUTY_RST;
        pwm_q    <= 1'b0;
      end else begin
        shadow_q <= shadow_d;
        active_q <= active_d;
        pwm_q    <= pwm_d;
      end
    end

    assign shadow_flat[gi*CNT_W +: CNT_W] = shadow_q;
    assign pwm_out[gi] = pwm_q;
  end

  // Out-of-range selections read as zero.
  always_comb begin
    duty_sel = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (ch_sel == CH_W'(i)) begin
        duty_sel = shadow_flat[i*CNT_W +: CNT_W];
      end
    end
  end

endmodule

// File: tb/tb_pwm_multi_ctrl.sv
// Randomised self-checking bench for pwm_multi_ctrl: a press-level duty model plus a
// per-period waveform monitor that rebuilds each expected PWM pattern from the duty rules.
module tb_pwm_multi_ctrl;
  import pwm_pkg::*;

  localparam int NCH  = 2;
  localparam int P    = 10;
  localparam int STEP = 1;
  localparam int DIV  = 2;

  logic           clk = 1'b0;
  logic           rst;
  logic           ena;
  logic           btn_inc;
  logic           btn_dec;
  logic           ch_sel;
  logic [1:0]     ch_sel3;
  logic           center_mode;
  logic [NCH-1:0] pwm_out;
  logic [3:0]     duty_sel;
  logic           period_strt;
  logic [2:0]     pwm_out3;
  logic [3:0]     duty_sel3;
  logic           period_strt3;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state
  int        cur_duty  [NCH];
  int        prev_duty [NCH];
  bit        trans     [NCH];
  pwm_mode_e cur_mode;
  int        shadow3   [3];

  always #5 clk = ~clk;

  pwm_multi_ctrl #(.NUM_CH(NCH), .PERIOD(P), .DUTY_STEP(STEP), .DEB_DIV(DIV)) dut (
    .clk         (clk),
    .rst         (rst),
    .ena         (ena),
    .btn_inc     (btn_inc),
    .btn_dec     (btn_dec),
    .ch_sel      (ch_sel),
    .center_mode (center_mode),
    .pwm_out     (pwm_out),
    .duty_sel    (duty_sel),
    .period_strt (period_strt)
  );

  pwm_multi_ctrl #(.NUM_CH(3), .PERIOD(P), .DUTY_STEP(STEP), .DEB_DIV(DIV)) dut3 (
    .clk         (clk),
    .rst         (rst),
    .ena         (ena),
    .btn_inc     (btn_inc),
    .btn_dec     (btn_dec),
    .ch_sel      (ch_sel3),
    .center_mode (center_mode),
    .pwm_out     (pwm_out3),
    .duty_sel    (duty_sel3),
    .period_strt (period_strt3)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %0d expected %0d", tag, $time, got, exp);
    end
  endtask

  function automatic int step_duty(input int d, input bit inc, input bit dec);
    if (inc && !dec) return (d + STEP > P) ? P : d + STEP;
    if (dec && !inc) return (d < STEP) ? 0 : d - STEP;
    return d;
  endfunction

  function automatic logic [P-1:0] exp_pat(input int d, input pwm_mode_e m);
    logic [P-1:0] r;
    int lo;
    r  = '0;
    lo = (P - d) / 2;
    for (int k = 0; k < P; k++) begin
      r[k] = (m == MODE_CENTER) ? (k >= lo && k < lo + d) : (k < d);
    end
    return r;
  endfunction

  task automatic tick_n(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_strt();
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < 4 * P && !seen; k++) begin
      @(negedge clk);
      if (period_strt) seen = 1'b1;
    end
    check_eq("strt_seen", 32'(seen), 1);
  endtask

  task automatic wait_periods(input int n);
    repeat (n) wait_strt();
  endtask

  task automatic model_reset();
    for (int i = 0; i < NCH; i++) begin
      cur_duty[i]  = P / 2;
      prev_duty[i] = P / 2;
      trans[i]     = 1'b0;
    end
    for (int i = 0; i < 3; i++) shadow3[i] = P / 2;
    cur_mode = MODE_EDGE;
  endtask

  task automatic do_press(input bit inc, input bit dec);
    int ch;
    int ch3;
    int hold;
    ch   = int'(ch_sel);
    ch3  = int'(ch_sel3);
    hold = int'($urandom_range(8, 20));
    prev_duty[ch] = cur_duty[ch];
    cur_duty[ch]  = step_duty(cur_duty[ch], inc, dec);
    trans[ch]     = 1'b1;
    if (ch3 < 3) shadow3[ch3] = step_duty(shadow3[ch3], inc, dec);
    btn_inc = inc;
    btn_dec = dec;
    tick_n(hold);
    btn_inc = 1'b0;
    btn_dec = 1'b0;
    tick_n(12);
    trans[ch] = 1'b0;
    check_eq("duty_sel", 32'(duty_sel), cur_duty[ch]);
    if (ch3 < 3) check_eq("duty_sel3", 32'(duty_sel3), shadow3[ch3]);
    $display("press inc=%0b dec=%0b hold=%0d ch=%0d duty=%0d | ch3=%0d duty3=%0d",
             inc, dec, hold, ch, duty_sel, ch3, duty_sel3);
  endtask

  task automatic flip_mode(input pwm_mode_e m);
    wait_strt();
    tick_n(2);
    center_mode = (m == MODE_CENTER);
    cur_mode    = m;
    $display("mode -> %s", m.name());
  endtask

  // Waveform monitor: collects one sample per enabled clock and checks whole periods.
  initial begin : monitor
    bit           valid;
    bit           first;
    int           n;
    logic [P-1:0] obs      [NCH];
    int           lat_duty [NCH];
    int           lat_alt  [NCH];
    bit           lat_amb  [NCH];
    pwm_mode_e    lat_mode;
    logic [P-1:0] want;
    first    = 1'b1;
    n        = 0;
    lat_mode = MODE_EDGE;
    for (int i = 0; i < NCH; i++) begin
      obs[i] = '0; lat_duty[i] = 0; lat_alt[i] = 0; lat_amb[i] = 1'b0;
    end
    forever begin
      @(posedge clk);
      valid = ena && !rst;
      @(negedge clk);
      if (rst) begin
        check_eq("rst_pwm", 32'({pwm_out3, pwm_out}), 0);
        check_eq("rst_strt", 32'(period_strt), 0);
        first = 1'b1;
        n     = 0;
      end else if (!valid) begin
        check_eq("ena_off_pwm", 32'({pwm_out3, pwm_out}), 0);
        check_eq("ena_off_strt", 32'(period_strt), 0);
      end else begin
        check_eq("strt3", 32'(period_strt3), 32'(period_strt));
        if (period_strt) begin
          if (!first) begin
            check_eq("period_len", n, P);
            for (int i = 0; i < NCH; i++) begin
              want = exp_pat(lat_duty[i], lat_mode);
              if (lat_amb[i] && obs[i] == exp_pat(lat_alt[i], lat_mode))
                want = exp_pat(lat_alt[i], lat_mode);
              check_eq((i == 0) ? "pat_ch0" : "pat_ch1", 32'(obs[i]), 32'(want));
            end
          end
          first    = 1'b0;
          n        = 0;
          lat_mode = cur_mode;
          for (int i = 0; i < NCH; i++) begin
            obs[i]      = '0;
            lat_duty[i] = trans[i] ? prev_duty[i] : cur_duty[i];
            lat_alt[i]  = cur_duty[i];
            lat_amb[i]  = trans[i];
          end
        end
        if (!first) begin
          if (n < P) begin
            for (int i = 0; i < NCH; i++) obs[i][n] = pwm_out[i];
          end
          n++;
        end
      end
    end
  end

  initial begin
    rst = 1'b1; ena = 1'b1; btn_inc = 1'b0; btn_dec = 1'b0;
    ch_sel = 1'b0; ch_sel3 = 2'd0; center_mode = 1'b0;
    model_reset();

    // Reset state
    tick_n(3);
    check_eq("rst_duty_ch0", 32'(duty_sel), P / 2);
    ch_sel = 1'b1; #1;
    check_eq("rst_duty_ch1", 32'(duty_sel), P / 2);
    rst = 1'b0;
    wait_periods(3);

    // Three increments on channel 1
    repeat (3) do_press(1'b1, 1'b0);
    check_eq("ch1_duty8", 32'(duty_sel), 8);
    wait_periods(3);

    // Saturation at both ends on channel 0
    ch_sel = 1'b0;
    repeat (7) do_press(1'b1, 1'b0);
    wait_periods(2);
    repeat (12) do_press(1'b0, 1'b1);
    wait_periods(2);

    // Centre alignment with duty 4, switched mid-period
    repeat (4) do_press(1'b1, 1'b0);
    flip_mode(MODE_CENTER);
    wait_periods(3);
    flip_mode(MODE_EDGE);
    wait_periods(2);

    // Simultaneous buttons, out-of-range channel on the 3-channel instance
    do_press(1'b1, 1'b1);
    ch_sel3 = 2'd3;
    do_press(1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      ch_sel3 = 2'(i); #1;
      check_eq("sel3_sweep", 32'(duty_sel3), shadow3[i]);
    end

    // Randomised presses with occasional alignment changes
    for (int it = 0; it < 30; it++) begin
      int kind;
      ch_sel  = 1'($urandom_range(0, 1));
      ch_sel3 = 2'($urandom_range(0, 3));
      kind    = int'($urandom_range(0, 5));
      do_press(kind <= 2 || kind == 5, kind >= 3);
      if ($urandom_range(0, 5) == 0)
        flip_mode((cur_mode == MODE_EDGE) ? MODE_CENTER : MODE_EDGE);
    end
    wait_periods(2);

    // Enable low: counter frozen, outputs low, presses ignored
    ch_sel = 1'b0;
    wait_strt();
    tick_n(3);
    ena = 1'b0;
    btn_inc = 1'b1;
    tick_n(10);
    btn_inc = 1'b0;
    tick_n(8);
    check_eq("ena_press_ignored", 32'(duty_sel), cur_duty[0]);
    ena = 1'b1;
    $display("ena freeze done, duty ch0=%0d", duty_sel);
    wait_periods(3);

    // Asynchronous reset mid-period with channel 0 driven fully high
    repeat (10) do_press(1'b1, 1'b0);
    wait_periods(2);
    wait_strt();
    tick_n(4);
    #3 rst = 1'b1;
    center_mode = 1'b0;
    model_reset();
    #1;
    check_eq("rst_async_pwm", 32'(pwm_out), 0);
    check_eq("rst_async_duty", 32'(duty_sel), P / 2);
    tick_n(3);
    rst = 1'b0;
    $display("reset released, duty ch0=%0d", duty_sel);
    wait_periods(3);
    ch_sel = 1'b1; #1;
    check_eq("post_rst_ch1", 32'(duty_sel), P / 2);
    wait_periods(1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
